// File: rtl/alu_sequencer_if.sv
// Request/response bundle between an ALU client and the ALU sequencer.
// The client drives requests and rsp_ready; the sequencer answers with req_ready and the FIFO head.
interface alu_sequencer_if #(
   parameter int TAG_W = 4
);
   logic             req_valid;
   logic             req_ready;
   logic [2:0]       req_op;
   logic [15:0]      req_a;
   logic [15:0]      req_b;
   logic             req_use_prev;
   logic [TAG_W-1:0] req_tag;

   logic             rsp_valid;
   logic             rsp_ready;
   logic [15:0]      rsp_result;
   logic [2:0]       rsp_cc;
   logic [TAG_W-1:0] rsp_tag;
   logic             rsp_err;

   modport master (
      output req_valid, req_op, req_a, req_b, req_use_prev, req_tag, rsp_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_cc, rsp_tag, rsp_err
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, req_use_prev, req_tag, rsp_ready,
      output req_ready, rsp_valid, rsp_result, rsp_cc, rsp_tag, rsp_err
   );
endinterface

// File: rtl/alu_sequencer.sv
// Front end for the 16-bit ALU: evaluates accepted requests in the same cycle and queues
// {result, cc, err, tag} in a small response FIFO; the last result can be chained in as operand A.
module alu_sequencer #(
   parameter int DEPTH = 2,
   parameter int TAG_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   alu_sequencer_if.slave    bus,
   output logic              busy
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [15:0]      res_mem [DEPTH];
   logic [2:0]       cc_mem  [DEPTH];
   logic             err_mem [DEPTH];
   logic [TAG_W-1:0] tag_mem [DEPTH];

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [15:0]   prev_result;

   logic [15:0] op_a;
   logic [3:0]  shamt;
   logic [15:0] alu_result;
   logic [2:0]  alu_cc;
   logic        alu_err;
   logic        accept;
   logic        pop;

   // req_ready depends only on the stored count, so a full FIFO stalls even during a pop.
   assign bus.req_ready = (count < FULL_COUNT);
   assign bus.rsp_valid = (count != '0);
   assign busy          = (count != '0);
   assign accept        = bus.req_valid && bus.req_ready;
   assign pop           = bus.rsp_valid && bus.rsp_ready;

   assign bus.rsp_result = bus.rsp_valid ? res_mem[rd_ptr] : '0;
   assign bus.rsp_cc     = bus.rsp_valid ? cc_mem[rd_ptr]  : '0;
   assign bus.rsp_err    = bus.rsp_valid ? err_mem[rd_ptr] : 1'b0;
   assign bus.rsp_tag    = bus.rsp_valid ? tag_mem[rd_ptr] : '0;

   // The ALU itself; illegal opcodes yield a zero result, which naturally reports Z.
   always_comb begin
      op_a       = bus.req_use_prev ? prev_result : bus.req_a;
      shamt      = bus.req_b[3:0];
      alu_result = '0;
      alu_err    = 1'b0;
      case (bus.req_op)
         3'd0:    alu_result = op_a + bus.req_b;
         3'd1:    alu_result = op_a & bus.req_b;
         3'd2:    alu_result = op_a ^ bus.req_b;
         3'd3:    alu_result = op_a << shamt;
         3'd4:    alu_result = op_a >> shamt;
         3'd5:    alu_result = $signed(op_a) >>> shamt;
         default: alu_err    = 1'b1;
      endcase
      alu_cc = {alu_result[15], (alu_result == '0), ~alu_result[15] & (alu_result != '0)};
   end

   // Entry storage carries no reset; the pointers and count decide what is valid.
   always_ff @(posedge clk) begin
      if (accept && !reset) begin
         res_mem[wr_ptr] <= alu_result;
         cc_mem[wr_ptr]  <= alu_cc;
         err_mem[wr_ptr] <= alu_err;
         tag_mem[wr_ptr] <= bus.req_tag;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         prev_result <= '0;
      end else begin
         if (accept) begin
            wr_ptr      <= wr_ptr + 1'b1;
            prev_result <= alu_result;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({accept, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized scoreboard bench for alu_sequencer: an arithmetic reference model predicts each
// response at accept time and a negedge monitor compares whatever the FIFO head presents.
module tb_alu_sequencer;
   localparam int DEPTH = 2;
   localparam int TAG_W = 4;

   typedef struct {
      logic [15:0]      res;
      logic [2:0]       cc;
      logic             err;
      logic [TAG_W-1:0] tag;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic busy;
   int   checks = 0;
   int   errors = 0;
   bit   rand_rr = 1'b0;
   longint model_prev = 0;
   exp_t sb[$];

   alu_sequencer_if #(.TAG_W(TAG_W)) ifc ();

   alu_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc.slave),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: results from plain integer arithmetic on the operation definitions.
   function automatic exp_t model(input logic [2:0] op, input logic [15:0] a_in, input logic [15:0] b,
                                  input logic use_prev, input logic [TAG_W-1:0] tag);
      exp_t   e;
      longint a, bb, d, r, s;
      a  = use_prev ? model_prev : longint'(a_in);
      bb = longint'(b);
      d  = longint'(1) << b[3:0];
      e.err = 1'b0;
      case (op)
         3'd0: r = (a + bb) % 65536;
         3'd1: r = a & bb;
         3'd2: r = a ^ bb;
         3'd3: r = (a * d) % 65536;
         3'd4: r = a / d;
         3'd5: begin
            s = (a >= 32768) ? a - 65536 : a;
            if (s < 0) r = 65536 - ((-s + d - 1) / d);
            else       r = s / d;
         end
         default: begin r = 0; e.err = 1'b1; end
      endcase
      e.res = r[15:0];
      if (r >= 32768)  e.cc = 3'b100;
      else if (r == 0) e.cc = 3'b010;
      else             e.cc = 3'b001;
      e.tag = tag;
      model_prev = r;
      return e;
   endfunction

   always @(negedge clk) begin
      if (reset === 1'b0 && ifc.rsp_valid === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_rsp: got tag 0x%0h result 0x%0h, expected no response", ifc.rsp_tag, ifc.rsp_result);
         end else begin
            checkOutput("rsp_result", 32'(ifc.rsp_result), 32'(sb[0].res));
            checkOutput("rsp_cc",     32'(ifc.rsp_cc),     32'(sb[0].cc));
            checkOutput("rsp_err",    32'(ifc.rsp_err),    32'(sb[0].err));
            checkOutput("rsp_tag",    32'(ifc.rsp_tag),    32'(sb[0].tag));
            if (ifc.rsp_ready === 1'b1) void'(sb.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_rr) ifc.rsp_ready = 1'($urandom_range(0, 1));
   endtask

   // Presents one request (starting just after an edge) and returns just after the accepting edge.
   task automatic applyStimulus(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                input logic use_prev, input logic [TAG_W-1:0] tag);
      int n = 0;
      ifc.req_op       = op;
      ifc.req_a        = a;
      ifc.req_b        = b;
      ifc.req_use_prev = use_prev;
      ifc.req_tag      = tag;
      ifc.req_valid    = 1'b1;
      while (ifc.req_ready !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      if (ifc.req_ready !== 1'b1) begin
         checkOutput("accept_timeout", 32'(ifc.req_ready), 32'd1);
      end else begin
         sb.push_back(model(op, a, b, use_prev, tag));
         tick();
      end
      ifc.req_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (busy !== 1'b0 && n < 500) begin
         tick();
         n++;
      end
      checkOutput("drain_busy", 32'(busy), 32'd0);
      checkOutput("drain_scoreboard", sb.size(), 0);
   endtask

   initial begin
      reset            = 1'b1;
      ifc.req_valid    = 1'b0;
      ifc.req_op       = '0;
      ifc.req_a        = '0;
      ifc.req_b        = '0;
      ifc.req_use_prev = 1'b0;
      ifc.req_tag      = '0;
      ifc.rsp_ready    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      checkOutput("reset_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
      checkOutput("reset_req_ready", 32'(ifc.req_ready), 32'd1);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_rsp_result", 32'(ifc.rsp_result), 32'd0);
      checkOutput("reset_rsp_tag", 32'(ifc.rsp_tag), 32'd0);

      ifc.rsp_ready = 1'b1;
      applyStimulus(3'd0, 16'h7FFF, 16'h0001, 1'b0, 4'd1);
      checkOutput("latency_rsp_valid", 32'(ifc.rsp_valid), 32'd1);
      checkOutput("add_ovf_result", 32'(ifc.rsp_result), 32'h8000);
      checkOutput("add_ovf_cc", 32'(ifc.rsp_cc), 32'b100);

      applyStimulus(3'd3, 16'h0003, 16'h0004, 1'b0, 4'd2);
      applyStimulus(3'd0, 16'hFFFF, 16'h0010, 1'b1, 4'd3);
      applyStimulus(3'd5, 16'h8000, 16'h0013, 1'b0, 4'd4);
      applyStimulus(3'd4, 16'h8000, 16'h0013, 1'b0, 4'd5);
      applyStimulus(3'd7, 16'h1234, 16'h0000, 1'b0, 4'd6);
      applyStimulus(3'd0, 16'hABCD, 16'h0005, 1'b1, 4'd7);
      drain();

      // Backpressure: two entries fill the FIFO, the third request must wait.
      ifc.rsp_ready = 1'b0;
      applyStimulus(3'd0, 16'h0010, 16'h0001, 1'b0, 4'd1);
      applyStimulus(3'd0, 16'h0020, 16'h0002, 1'b0, 4'd2);
      checkOutput("full_req_ready", 32'(ifc.req_ready), 32'd0);
      checkOutput("full_busy", 32'(busy), 32'd1);
      ifc.req_op = 3'd0; ifc.req_a = 16'h0030; ifc.req_b = 16'h0003;
      ifc.req_use_prev = 1'b0; ifc.req_tag = 4'd3; ifc.req_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("stall_req_ready", 32'(ifc.req_ready), 32'd0);
      end
      ifc.rsp_ready = 1'b1;
      applyStimulus(3'd0, 16'h0030, 16'h0003, 1'b0, 4'd3);
      drain();

      // Reset with entries queued discards them and clears the chained operand.
      ifc.rsp_ready = 1'b0;
      applyStimulus(3'd2, 16'h5A5A, 16'h0F0F, 1'b0, 4'd8);
      applyStimulus(3'd1, 16'hFFFF, 16'h1234, 1'b0, 4'd9);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      sb.delete();
      model_prev = 0;
      checkOutput("midreset_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
      checkOutput("midreset_req_ready", 32'(ifc.req_ready), 32'd1);
      checkOutput("midreset_busy", 32'(busy), 32'd0);
      ifc.rsp_ready = 1'b1;
      applyStimulus(3'd0, 16'h4321, 16'h0001, 1'b1, 4'd10);
      checkOutput("post_reset_chain", 32'(ifc.rsp_result), 32'h0001);
      drain();

      rand_rr = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) tick();
         applyStimulus(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
                       1'($urandom_range(0, 1)), TAG_W'($urandom));
      end
      rand_rr = 1'b0;
      ifc.rsp_ready = 1'b1;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
